dem_uart_nasti_host: RTL

//  NASTI-lite (AXI4-lite) initiator that drives the 16550-style register port of the debug UART module.

---
 rtl/dem_uart_nasti_host_if.sv | 37 +++
 rtl/dem_uart_nasti_host.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dem_uart_nasti_host_if.sv
// NASTI-lite (AXI4-lite) bus bundle between the UART host initiator and the UART register port.
interface dem_uart_nasti_host_if #(
  parameter int unsigned ADDR_WIDTH = 13
) ();
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [31:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [31:0]           w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output ar_addr, ar_valid, input  ar_ready,
    input  r_data, r_resp, r_valid, output r_ready,
    output aw_addr, aw_valid, input  aw_ready,
    output w_data, w_valid, input  w_ready,
    input  b_resp, b_valid, output b_ready
  );

  modport slave (
    input  ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input  r_ready,
    input  aw_addr, aw_valid, output aw_ready,
    input  w_data, w_valid, output w_ready,
    output b_resp, b_valid, input  b_ready
  );
endinterface

// File: rtl/dem_uart_nasti_host.sv
// NASTI-lite initiator for a 16550-style UART: polls LSR, moves RBR bytes out to a stream and
// stream bytes into THR. One bus transaction outstanding at a time.
module dem_uart_nasti_host #(
  parameter int unsigned ADDR_WIDTH    = 13,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          err_o,
  dem_uart_nasti_host_if.master         bus
);

  localparam logic [ADDR_WIDTH-1:0] RbrAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LsrAddr = ADDR_WIDTH'(BASE_ADDR + 32'd20);
  localparam int unsigned CntW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  typedef enum logic [2:0] {
    StPollAr, StPollR, StDecide, StRbrAr, StRbrR, StWr, StWrB, StWait
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      lsr_q, lsr_d;
  logic [7:0]      wbyte_q, wbyte_d;
  logic            aw_pend_q, aw_pend_d;
  logic            w_pend_q, w_pend_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            err_q, err_d;

  logic r_ok, b_ok;
  logic unused_rdata;

  assign r_ok         = (bus.r_resp == 2'b00);
  assign b_ok         = (bus.b_resp == 2'b00);
  assign unused_rdata = ^bus.r_data[31:8];

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StPollAr;
      lsr_q      <= 8'h00;
      wbyte_q    <= 8'h00;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      cnt_q      <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lsr_q      <= lsr_d;
      wbyte_q    <= wbyte_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic, tx acceptance and error detection.
  always_comb begin
    state_d    = state_q;
    lsr_d      = lsr_q;
    wbyte_d    = wbyte_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_d      = 1'b0;
    tx_ready_o = 1'b0;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      StPollAr: if (bus.ar_ready) state_d = StPollR;
      StPollR: begin
        if (bus.r_valid) begin
          // A failed LSR read looks like "nothing to do" so we simply back off.
          lsr_d   = r_ok ? bus.r_data[7:0] : 8'h00;
          err_d   = !r_ok;
          state_d = StDecide;
        end
      end
      StDecide: begin
        if (lsr_q[0] && !rx_valid_q) begin
          state_d = StRbrAr;
        end else if (lsr_q[5] && tx_valid_i) begin
          tx_ready_o = 1'b1;
          wbyte_d    = tx_data_i;
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          state_d    = StWr;
        end else begin
          cnt_d   = CntW'(POLL_INTERVAL - 1);
          state_d = StWait;
        end
      end
      StRbrAr: if (bus.ar_ready) state_d = StRbrR;
      StRbrR: begin
        if (bus.r_valid) begin
          if (r_ok) begin
            rx_data_d  = bus.r_data[7:0];
            rx_valid_d = 1'b1;
          end
          err_d   = !r_ok;
          state_d = StPollAr;
        end
      end
      StWr: begin
        if (bus.aw_ready) aw_pend_d = 1'b0;
        if (bus.w_ready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) state_d = StWrB;
      end
      StWrB: begin
        if (bus.b_valid) begin
          err_d   = !b_ok;
          state_d = StPollAr;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StPollAr;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = StPollAr;
    endcase
  end

  // Bus outputs decoded from state; held low while reset is asserted.
  always_comb begin
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.w_valid  = 1'b0;
    bus.w_data   = 32'h0;
    bus.b_ready  = 1'b0;
    if (rstn) begin
      case (state_q)
        StPollAr: begin
          bus.ar_valid = 1'b1;
          bus.ar_addr  = LsrAddr;
        end
        StRbrAr: begin
          bus.ar_valid = 1'b1;
          bus.ar_addr  = RbrAddr;
        end
        StPollR, StRbrR: bus.r_ready = 1'b1;
        StWr: begin
          bus.aw_valid = aw_pend_q;
          bus.aw_addr  = aw_pend_q ? RbrAddr : '0;
          bus.w_valid  = w_pend_q;
          bus.w_data   = w_pend_q ? {24'h0, wbyte_q} : 32'h0;
        end
        StWrB: bus.b_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign err_o      = err_q;

endmodule
